// File: rtl/mux_arb8.sv
// mux_arb8: registered N-channel mux with valid/ready handshakes, manual or round-robin channel selection.
module mux_arb8 #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   MODE,
  input  logic [SELW-1:0]        SEL,
  input  logic [NCH*WIDTH-1:0]   IN_DATA,
  input  logic [NCH-1:0]         IN_VALID,
  output logic [NCH-1:0]         IN_READY,
  output logic [WIDTH-1:0]       MUX_OUT,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [SELW-1:0]        OUT_CH
);
  logic [SELW-1:0]  ptr, rr_g, g;
  logic             rr_found, man_ok, grant, xfer;
  logic [WIDTH-1:0] data_sel;
  always_comb begin
    rr_found = 1'b0;
    rr_g = '0;
    man_ok = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!rr_found && IN_VALID[k] && k >= int'(ptr)) begin
        rr_found = 1'b1;
        rr_g = SELW'(k);
      end
      if (int'(SEL) == k && IN_VALID[k]) man_ok = 1'b1;
    end
    // wrap-around half of the scan: channels below the pointer
    for (int k = 0; k < NCH; k++) begin
      if (!rr_found && IN_VALID[k] && k < int'(ptr)) begin
        rr_found = 1'b1;
        rr_g = SELW'(k);
      end
    end
  end
  assign g     = MODE ? rr_g : SEL;
  assign grant = MODE ? rr_found : man_ok;
  assign xfer  = !RST && grant && (!OUT_VALID || OUT_READY);
  always_comb begin
    data_sel = '0;
    IN_READY = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(g) == k) data_sel = IN_DATA[k*WIDTH +: WIDTH];
      IN_READY[k] = xfer && int'(g) == k;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      MUX_OUT <= '0;
      OUT_CH <= '0;
      OUT_VALID <= 1'b0;
      ptr <= '0;
    end else if (xfer) begin
      MUX_OUT <= data_sel;
      OUT_CH <= g;
      OUT_VALID <= 1'b1;
      if (MODE) ptr <= (int'(g) == NCH - 1) ? '0 : g + SELW'(1);
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end
endmodule
